v_alu_arb: RTL and testbench

V_ALU_ARB -- requirements
Module: v_alu_arb

---
 rtl/v_alu_arb_pkg.sv | 27 ++
 rtl/v_alu_arb_rr.sv | 34 +++
 rtl/v_alu_arb.sv | 117 +++++++++++
 tb/tb_v_alu_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_alu_arb_pkg.sv
// Shared vector ALU definitions: opcode encodings, bus widths and
// the per-opcode occupancy helper used by the ALU arbiter.
package v_alu_arb_pkg;

    localparam int VREG_W   = 256;
    localparam int LANE_W   = 32;
    localparam int VLMAX    = VREG_W / LANE_W;
    localparam int ALU_OP_W = 4;
    localparam int CNT_W    = 8;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t VALU_OP_NOP = 4'h0;
    localparam alu_op_t VALU_OP_ADD = 4'h1;
    localparam alu_op_t VALU_OP_MUL = 4'h2;

    // Cycles an operand set stays on the shared ALU. Anything that
    // is not a multiply (including NOP/unknown) uses the add latency.
    function automatic logic [CNT_W-1:0] op_lat(
        input alu_op_t op,
        input int      mul_lat,
        input int      add_lat
    );
        return (op == VALU_OP_MUL) ? CNT_W'(mul_lat) : CNT_W'(add_lat);
    endfunction

endpackage

// File: rtl/v_alu_arb_rr.sv
// Two-way round-robin arbiter, module v_rr_arb2.
// Ports: clk, rst (async active-low), valid[1:0], en (pointer update),
//        grant[1:0] one-hot.
module v_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       en,
    output logic [1:0] grant
);

    // Names the requester preferred when both are valid.
    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the other side becomes preferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (en) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/v_alu_arb.sv
// Shares one combinational vector ALU between two requesters.
// Ports: clk, rst (async active-low); req0_*/req1_* valid/ready
//        requests; alu_* to/from the external ALU; rsp_* response.
module v_alu_arb
    import v_alu_arb_pkg::*;
#(
    parameter int VLEN_W  = VREG_W,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  alu_op_t           req0_op,
    input  logic [VLEN_W-1:0] req0_vs1,
    input  logic [VLEN_W-1:0] req0_vs2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  alu_op_t           req1_op,
    input  logic [VLEN_W-1:0] req1_vs1,
    input  logic [VLEN_W-1:0] req1_vs2,
    output alu_op_t           alu_opcode_o,
    output logic [VLEN_W-1:0] alu_vs1_o,
    output logic [VLEN_W-1:0] alu_vs2_o,
    input  logic [VLEN_W-1:0] alu_result_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [VLEN_W-1:0] rsp_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    alu_op_t           op_q;
    logic [VLEN_W-1:0] vs1_q;
    logic [VLEN_W-1:0] vs2_q;
    logic [VLEN_W-1:0] data_q;
    logic              id_q;

    logic [1:0]        arb_valid;
    logic [1:0]        grant;
    logic              take;
    alu_op_t           sel_op;

    // Requests are only offered in IDLE; gating with rst keeps both
    // readies low while reset is held even if a requester is valid.
    assign arb_valid = (state == IDLE && rst) ? {req1_valid, req0_valid}
                                              : 2'b00;
    assign take      = |grant;
    assign sel_op    = grant[1] ? req1_op : req0_op;

    v_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (arb_valid),
        .en    (take),
        .grant (grant)
    );

    assign req0_ready   = grant[0];
    assign req1_ready   = grant[1];

    assign alu_opcode_o = (state == EXEC) ? op_q  : VALU_OP_NOP;
    assign alu_vs1_o    = (state == EXEC) ? vs1_q : '0;
    assign alu_vs2_o    = (state == EXEC) ? vs2_q : '0;

    assign rsp_valid    = (state == RESP);
    assign rsp_id       = id_q;
    assign rsp_data     = data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= VALU_OP_NOP;
            vs1_q  <= '0;
            vs2_q  <= '0;
            data_q <= '0;
            id_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        op_q  <= sel_op;
                        vs1_q <= grant[1] ? req1_vs1 : req0_vs1;
                        vs2_q <= grant[1] ? req1_vs2 : req0_vs2;
                        id_q  <= grant[1];
                        cnt   <= op_lat(sel_op, MUL_LAT, ADD_LAT);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                    // Last held cycle: the ALU output is final here.
                    if (cnt <= CNT_W'(1)) begin
                        data_q <= alu_result_i;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_alu_arb.sv
// Self-checking bench for v_alu_arb with a behavioural lane ALU.
// Ports: drives all v_alu_arb inputs, checks all outputs.
module tb_v_alu_arb;
    import v_alu_arb_pkg::*;

    localparam int W = VREG_W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    alu_op_t      req0_op, req1_op, alu_opcode_o;
    logic [W-1:0] req0_vs1, req0_vs2, req1_vs1, req1_vs2;
    logic [W-1:0] alu_vs1_o, alu_vs2_o, alu_result_i;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    v_alu_arb #(
        .VLEN_W  (W),
        .MUL_LAT (2),
        .ADD_LAT (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_vs1     (req0_vs1),
        .req0_vs2     (req0_vs2),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_vs1     (req1_vs1),
        .req1_vs2     (req1_vs2),
        .alu_opcode_o (alu_opcode_o),
        .alu_vs1_o    (alu_vs1_o),
        .alu_vs2_o    (alu_vs2_o),
        .alu_result_i (alu_result_i),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
    );

    // External ALU: independent 32-bit lanes, NOP/unknown give zero.
    always_comb begin
        alu_result_i = '0;
        for (int i = 0; i < VLMAX; i++) begin
            case (alu_opcode_o)
                VALU_OP_ADD: alu_result_i[i*LANE_W +: LANE_W] =
                    alu_vs1_o[i*LANE_W +: LANE_W] + alu_vs2_o[i*LANE_W +: LANE_W];
                VALU_OP_MUL: alu_result_i[i*LANE_W +: LANE_W] =
                    alu_vs1_o[i*LANE_W +: LANE_W] * alu_vs2_o[i*LANE_W +: LANE_W];
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        v0;
        logic        v1;
        alu_op_t     op0;
        alu_op_t     op1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        int          eid;
        logic [31:0] elane;
        int          elat;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [W-1:0] rep(input logic [31:0] l);
        return {VLMAX{l}};
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns once the handshake edge has passed.
    task automatic wait_grant(output int gid);
        gid = -1;
        for (int n = 0; n < 20; n++) begin
            if (req0_ready || req1_ready) begin
                chk("ready_onehot", W'(req0_ready & req1_ready), '0);
                chk("idle_op_nop", W'(alu_opcode_o), W'(VALU_OP_NOP));
                gid = req1_ready ? 1 : 0;
                tick();
                break;
            end
            tick();
        end
        if (gid < 0) chk("grant_timeout", '0, W'(1));
    endtask

    task automatic wait_rsp(input alu_op_t eop, output int lat);
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            lat++;
            if (rsp_valid) begin
                chk("resp_op_nop", W'(alu_opcode_o), W'(VALU_OP_NOP));
                break;
            end
            chk("exec_op", W'(alu_opcode_o), W'(eop));
        end
        if (!rsp_valid) chk("rsp_timeout", '0, W'(1));
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", W'(rsp_valid), '0);
    endtask

    task automatic run_vec(input vec_t v);
        int gid;
        int lat;
        req0_valid = v.v0;
        req0_op    = v.op0;
        req0_vs1   = rep(v.a0);
        req0_vs2   = rep(v.b0);
        req1_valid = v.v1;
        req1_op    = v.op1;
        req1_vs1   = rep(v.a1);
        req1_vs2   = rep(v.b1);
        #1;
        wait_grant(gid);
        chk("grant_id", W'(gid), W'(v.eid));
        if (gid == 1) req1_valid = 1'b0;
        else          req0_valid = 1'b0;
        wait_rsp((gid == 1) ? v.op1 : v.op0, lat);
        chk("latency", W'(lat), W'(v.elat));
        chk("rsp_id", W'(rsp_id), W'(v.eid));
        chk("rsp_data", rsp_data, rep(v.elane));
        accept();
    endtask

    initial begin
        int gid;
        int lat;
        logic [W-1:0] hold;
        logic seen;

        tbl[0] = '{1'b1, 1'b0, VALU_OP_ADD, VALU_OP_NOP, 32'd1, 32'd2,
                   32'd0, 32'd0, 0, 32'd3, 1};
        tbl[1] = '{1'b0, 1'b1, VALU_OP_NOP, VALU_OP_MUL, 32'd0, 32'd0,
                   32'd3, 32'd4, 1, 32'd12, 2};
        tbl[2] = '{1'b1, 1'b1, VALU_OP_ADD, VALU_OP_MUL, 32'd5, 32'd6,
                   32'd2, 32'd7, 0, 32'd11, 1};
        tbl[3] = '{1'b1, 1'b1, VALU_OP_ADD, VALU_OP_MUL, 32'd5, 32'd6,
                   32'd2, 32'd7, 1, 32'd14, 2};
        tbl[4] = '{1'b1, 1'b1, VALU_OP_ADD, VALU_OP_MUL, 32'd5, 32'd6,
                   32'd2, 32'd7, 0, 32'd11, 1};
        tbl[5] = '{1'b1, 1'b1, VALU_OP_ADD, VALU_OP_MUL, 32'd5, 32'd6,
                   32'd2, 32'd7, 1, 32'd14, 2};
        tbl[6] = '{1'b0, 1'b1, VALU_OP_NOP, VALU_OP_ADD, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1};
        tbl[7] = '{1'b1, 1'b0, VALU_OP_NOP, VALU_OP_NOP, 32'd5, 32'd6,
                   32'd0, 32'd0, 0, 32'd0, 1};
        tbl[8] = '{1'b1, 1'b0, VALU_OP_MUL, VALU_OP_NOP, 32'hFFFF,
                   32'hFFFF, 32'd0, 32'd0, 0, 32'hFFFE_0001, 2};
        tbl[9] = '{1'b1, 1'b1, VALU_OP_ADD, 4'hF, 32'd1, 32'd1,
                   32'd9, 32'd9, 1, 32'd0, 1};

        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_op    = VALU_OP_ADD;
        req1_op    = VALU_OP_ADD;
        req0_vs1   = '0;
        req0_vs2   = '0;
        req1_vs1   = '0;
        req1_vs2   = '0;
        rsp_ready  = 1'b0;
        tick();
        tick();
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_ready", W'({req1_ready, req0_ready}), '0);
        chk("rst_alu_op", W'(alu_opcode_o), W'(VALU_OP_NOP));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Backpressure: response held, a pending request must wait.
        req0_valid = 1'b1;
        req0_op    = VALU_OP_ADD;
        req0_vs1   = rep(32'd7);
        req0_vs2   = rep(32'd8);
        req1_valid = 1'b0;
        #1;
        wait_grant(gid);
        chk("bp_gid", W'(gid), '0);
        req0_valid = 1'b0;
        wait_rsp(VALU_OP_ADD, lat);
        hold = rsp_data;
        chk("bp_data", hold, rep(32'd15));
        req1_valid = 1'b1;
        req1_op    = VALU_OP_ADD;
        req1_vs1   = rep(32'd1);
        req1_vs2   = rep(32'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", W'(rsp_valid), W'(1));
            chk("bp_stable", rsp_data, hold);
            chk("bp_no_ready", W'({req1_ready, req0_ready}), '0);
            tick();
        end
        accept();
        #1;
        chk("bp_next_grant", W'({req1_ready, req0_ready}), W'(2'b10));
        wait_grant(gid);
        chk("bp_gid2", W'(gid), W'(1));
        req1_valid = 1'b0;
        wait_rsp(VALU_OP_ADD, lat);
        chk("bp_data2", rsp_data, rep(32'd2));
        chk("bp_id2", W'(rsp_id), W'(1));
        accept();

        // Reset during a multiply: pointer was moved to 1 by this grant.
        req0_valid = 1'b1;
        req0_op    = VALU_OP_MUL;
        req0_vs1   = rep(32'd3);
        req0_vs2   = rep(32'd5);
        #1;
        wait_grant(gid);
        chk("rm_gid", W'(gid), '0);
        req0_valid = 1'b0;
        chk("rm_exec_op", W'(alu_opcode_o), W'(VALU_OP_MUL));
        chk("rm_exec_vs1", alu_vs1_o, rep(32'd3));
        rst = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rm_rsp_valid", W'(rsp_valid), '0);
        chk("rm_alu_op", W'(alu_opcode_o), W'(VALU_OP_NOP));
        chk("rm_alu_vs1", alu_vs1_o, '0);
        chk("rm_alu_vs2", alu_vs2_o, '0);
        chk("rm_rsp_data", rsp_data, '0);
        chk("rm_rsp_id", W'(rsp_id), '0);
        chk("rm_ready", W'({req1_ready, req0_ready}), '0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | rsp_valid;
        end
        chk("rm_no_rsp", W'(seen), '0);
        req0_valid = 1'b1;
        req0_op    = VALU_OP_ADD;
        req0_vs1   = rep(32'd1);
        req0_vs2   = rep(32'd2);
        req1_valid = 1'b1;
        req1_op    = VALU_OP_MUL;
        req1_vs1   = rep(32'd4);
        req1_vs2   = rep(32'd4);
        #1;
        chk("rm_ptr_ready", W'({req1_ready, req0_ready}), W'(2'b01));
        wait_grant(gid);
        chk("rm_ptr_gid", W'(gid), '0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(VALU_OP_ADD, lat);
        chk("rm_lat", W'(lat), W'(1));
        chk("rm_data", rsp_data, rep(32'd3));
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
